// File: rtl/rv_isa_pkg.sv
// Shared RV32I decode definitions: opcodes, format codes, decoded bundle and
// the storage states of the decode stage.
package rv_isa_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // FMT_NONE is zero so a reset bundle reads as "no format".
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_R    = 3'd1;
    localparam logic [2:0] FMT_I    = 3'd2;
    localparam logic [2:0] FMT_S    = 3'd3;
    localparam logic [2:0] FMT_B    = 3'd4;
    localparam logic [2:0] FMT_U    = 3'd5;
    localparam logic [2:0] FMT_J    = 3'd6;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/rv_field_decode.sv
// Combinational RV32I field splitter; fields a format does not carry are forced
// to zero so each per-format ALU can consume them directly.
module rv_field_decode
    import rv_isa_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  fmt,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output logic        illegal
);

    always_comb begin
        opcode  = instr[6:0];
        fmt     = FMT_NONE;
        rd      = '0;
        rs1     = '0;
        rs2     = '0;
        funct3  = '0;
        funct7  = '0;
        imm     = '0;

        // Every legal opcode ends in 2'b11, so a full 7-bit match also
        // rejects compressed/reserved encodings.
        case (instr[6:0])
            OP_R:                      fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  fmt = FMT_I;
            OP_STORE:                  fmt = FMT_S;
            OP_BRANCH:                 fmt = FMT_B;
            OP_LUI, OP_AUIPC:          fmt = FMT_U;
            OP_JAL:                    fmt = FMT_J;
            default:                   fmt = FMT_NONE;
        endcase
        illegal = (fmt == FMT_NONE);

        case (fmt)
            FMT_R: begin
                rd = instr[11:7]; rs1 = instr[19:15]; rs2 = instr[24:20];
                funct3 = instr[14:12]; funct7 = instr[31:25];
            end
            FMT_I: begin
                rd = instr[11:7]; rs1 = instr[19:15]; funct3 = instr[14:12];
                imm = {{20{instr[31]}}, instr[31:20]};
            end
            FMT_S: begin
                rs1 = instr[19:15]; rs2 = instr[24:20]; funct3 = instr[14:12];
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            FMT_B: begin
                rs1 = instr[19:15]; rs2 = instr[24:20]; funct3 = instr[14:12];
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            FMT_U: begin
                rd = instr[11:7];
                imm = {instr[31:12], 12'b0};
            end
            FMT_J: begin
                rd = instr[11:7];
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: one registered output slot plus a one-entry skid buffer,
// so oINSTR_READY can be a flop while still sustaining one word per cycle.
module instr_decode_stage
    import rv_isa_pkg::*;
#(
    parameter int XLEN  = rv_isa_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             iFLUSH,
    input  logic [31:0]      iINSTR,
    input  logic [XLEN-1:0]  iPC,
    input  logic             iINSTR_VALID,
    output logic             oINSTR_READY,
    output logic             oVALID,
    input  logic             iREADY,
    output logic [XLEN-1:0]  oPC,
    output logic [6:0]       oOPCODE,
    output logic [2:0]       oFMT,
    output logic [4:0]       oRD,
    output logic [4:0]       oRS1,
    output logic [4:0]       oRS2,
    output logic [2:0]       oFUNCT3,
    output logic [6:0]       oFUNCT7,
    output logic [XLEN-1:0]  oIMM,
    output logic             oILLEGAL,
    output logic [CNT_W-1:0] oDEC_CNT
);

    dec_t in_dec;

    rv_field_decode u_field_decode (
        .instr   (iINSTR),
        .opcode  (in_dec.opcode),
        .fmt     (in_dec.fmt),
        .rd      (in_dec.rd),
        .rs1     (in_dec.rs1),
        .rs2     (in_dec.rs2),
        .funct3  (in_dec.funct3),
        .funct7  (in_dec.funct7),
        .imm     (in_dec.imm),
        .illegal (in_dec.illegal)
    );

    stage_state_e    state_q, state_d;
    logic            ready_q, ready_d;
    dec_t            out_dec_q, out_dec_d, skid_dec_q, skid_dec_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            in_fire, out_fire;

    assign in_fire  = iINSTR_VALID & ready_q;
    assign out_fire = (state_q != ST_EMPTY) & iREADY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_EMPTY;
            ready_q    <= 1'b1;
            out_dec_q  <= '0;
            skid_dec_q <= '0;
            out_pc_q   <= '0;
            skid_pc_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            out_dec_q  <= out_dec_d;
            skid_dec_q <= skid_dec_d;
            out_pc_q   <= out_pc_d;
            skid_pc_q  <= skid_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (iFLUSH) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_fire) state_d = ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_fire)      state_d = ST_TWO;
                    else if (!in_fire && out_fire) state_d = ST_EMPTY;
                end
                ST_TWO:   if (out_fire) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Datapath loads; flush only resets occupancy, stale payload is harmless.
    always_comb begin
        out_dec_d  = out_dec_q;
        out_pc_d   = out_pc_q;
        skid_dec_d = skid_dec_q;
        skid_pc_d  = skid_pc_q;
        ready_d    = (state_d != ST_TWO);
        cnt_d      = cnt_q;
        if (!iFLUSH) begin
            if (in_fire)
                cnt_d = cnt_q + 1'b1;
            if (in_fire && (state_q == ST_EMPTY || out_fire)) begin
                out_dec_d = in_dec;
                out_pc_d  = iPC;
            end else if (in_fire && state_q == ST_ONE) begin
                skid_dec_d = in_dec;
                skid_pc_d  = iPC;
            end else if (state_q == ST_TWO && out_fire) begin
                out_dec_d = skid_dec_q;
                out_pc_d  = skid_pc_q;
            end
        end
    end

    always_comb begin
        oINSTR_READY = ready_q;
        oVALID       = (state_q != ST_EMPTY);
        oPC          = out_pc_q;
        oOPCODE      = out_dec_q.opcode;
        oFMT         = out_dec_q.fmt;
        oRD          = out_dec_q.rd;
        oRS1         = out_dec_q.rs1;
        oRS2         = out_dec_q.rs2;
        oFUNCT3      = out_dec_q.funct3;
        oFUNCT7      = out_dec_q.funct7;
        oIMM         = out_dec_q.imm;
        oILLEGAL     = out_dec_q.illegal;
        oDEC_CNT     = cnt_q;
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed ISA cases plus a random
// valid/ready/flush soak against a queue-based occupancy and decode model.
module tb_instr_decode_stage;
    import rv_isa_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        iFLUSH, iINSTR_VALID, iREADY;
    logic [31:0] iINSTR, iPC;
    logic        oINSTR_READY, oVALID, oILLEGAL;
    logic [31:0] oPC, oIMM, oDEC_CNT;
    logic [6:0]  oOPCODE, oFUNCT7;
    logic [2:0]  oFMT, oFUNCT3;
    logic [4:0]  oRD, oRS1, oRS2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    item_t       mq[$];
    logic [31:0] m_cnt = '0;

    instr_decode_stage #(.XLEN(32), .CNT_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .iFLUSH(iFLUSH), .iINSTR(iINSTR), .iPC(iPC),
        .iINSTR_VALID(iINSTR_VALID), .oINSTR_READY(oINSTR_READY), .oVALID(oVALID),
        .iREADY(iREADY), .oPC(oPC), .oOPCODE(oOPCODE), .oFMT(oFMT), .oRD(oRD),
        .oRS1(oRS1), .oRS2(oRS2), .oFUNCT3(oFUNCT3), .oFUNCT7(oFUNCT7),
        .oIMM(oIMM), .oILLEGAL(oILLEGAL), .oDEC_CNT(oDEC_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference decode built from the ISA tables: pick the format, then take
    // only the fields that format owns and sign-extend immediates arithmetically.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t        d;
        int          v;
        logic [11:0] s12;
        logic [12:0] b13;
        logic [20:0] j21;
        d = '0;
        d.opcode = w[6:0];
        if (w[6:0] == OP_R) d.fmt = FMT_R;
        else if (w[6:0] == OP_IMM || w[6:0] == OP_LOAD || w[6:0] == OP_JALR) d.fmt = FMT_I;
        else if (w[6:0] == OP_STORE) d.fmt = FMT_S;
        else if (w[6:0] == OP_BRANCH) d.fmt = FMT_B;
        else if (w[6:0] == OP_LUI || w[6:0] == OP_AUIPC) d.fmt = FMT_U;
        else if (w[6:0] == OP_JAL) d.fmt = FMT_J;
        else d.fmt = FMT_NONE;
        d.illegal = (d.fmt == FMT_NONE);
        if (d.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) d.rd = w[11:7];
        if (d.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) begin
            d.rs1 = w[19:15];
            d.funct3 = w[14:12];
        end
        if (d.fmt inside {FMT_R, FMT_S, FMT_B}) d.rs2 = w[24:20];
        if (d.fmt == FMT_R) d.funct7 = w[31:25];
        v = 0;
        case (d.fmt)
            FMT_I: v = $signed(w[31:20]);
            FMT_S: begin s12 = {w[31:25], w[11:7]}; v = $signed(s12); end
            FMT_B: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; v = $signed(b13); end
            FMT_U: v = int'(w & 32'hFFFF_F000);
            FMT_J: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; v = $signed(j21); end
            default: v = 0;
        endcase
        d.imm = v;
        return d;
    endfunction

    // One clock: drive inputs, predict the fires from model occupancy, update model.
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p,
                        input logic rdy, input logic fl);
        bit in_f, out_f;
        iINSTR_VALID = v; iINSTR = w; iPC = p; iREADY = rdy; iFLUSH = fl;
        in_f  = v && (mq.size() < 2);
        out_f = (mq.size() > 0) && rdy;
        @(posedge CLK);
        if (fl) begin
            mq.delete();
        end else begin
            if (out_f) begin
                $display("txn out pc=%08h instr=%08h", mq[0].pc, mq[0].instr);
                void'(mq.pop_front());
            end
            if (in_f) begin
                mq.push_back('{pc: p, instr: w});
                m_cnt = m_cnt + 1;
            end
        end
        #1;
        iINSTR_VALID = 1'b0; iFLUSH = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; iFLUSH = 0; iINSTR_VALID = 0; iREADY = 0; iINSTR = '0; iPC = '0;
        #12;
        checks++;
        if ({oVALID, oPC, oOPCODE, oFMT, oRD, oRS1, oRS2, oFUNCT3, oFUNCT7, oIMM, oILLEGAL, oDEC_CNT} !== '0) begin
            errors++; $display("FAIL reset_outputs: got valid=%b pc=%h fmt=%0d imm=%h cnt=%0d, need all 0",
                               oVALID, oPC, oFMT, oIMM, oDEC_CNT);
        end
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (oINSTR_READY !== 1'b1 || oVALID !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got ready=%b valid=%b, need 1/0", oINSTR_READY, oVALID);
        end
    endtask

    task automatic test_addi();
        step(1, 32'hFFB1_0093, 32'h100, 1, 0);
        checks++;
        if (oVALID !== 1 || oFMT !== FMT_I || oRD !== 5'd1 || oRS1 !== 5'd2 || oRS2 !== 5'd0
            || oIMM !== 32'hFFFF_FFFB || oPC !== 32'h100) begin
            errors++; $display("FAIL addi: got v=%b fmt=%0d rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h, need 1 %0d 1 2 0 fffffffb 100",
                               oVALID, oFMT, oRD, oRS1, oRS2, oIMM, oPC, FMT_I);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (oVALID !== 0) begin errors++; $display("FAIL addi_drain: got valid=%b, need 0", oVALID); end
    endtask

    task automatic test_store_jal();
        step(1, 32'h0051_2423, 32'h104, 1, 0);
        checks++;
        if (oFMT !== FMT_S || oRD !== 0 || oRS1 !== 5'd2 || oRS2 !== 5'd5 || oFUNCT3 !== 3'd2 || oIMM !== 32'd8) begin
            errors++; $display("FAIL sw: got fmt=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%h, need %0d 0 2 5 2 8",
                               oFMT, oRD, oRS1, oRS2, oFUNCT3, oIMM, FMT_S);
        end
        step(1, 32'h0010_00EF, 32'h108, 1, 0);
        checks++;
        if (oFMT !== FMT_J || oRD !== 5'd1 || oRS1 !== 0 || oRS2 !== 0 || oFUNCT3 !== 0 || oIMM !== 32'h800) begin
            errors++; $display("FAIL jal: got fmt=%0d rd=%0d rs1=%0d imm=%h, need %0d 1 0 800",
                               oFMT, oRD, oRS1, oIMM, FMT_J);
        end
        step(0, 0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h200; exp_pc[1] = 32'h204; exp_pc[2] = 32'h208;
        step(1, 32'h0020_81B3, 32'h200, 0, 0);
        checks++;
        if (oINSTR_READY !== 1) begin errors++; $display("FAIL b2b_ready1: got %b, need 1", oINSTR_READY); end
        step(1, 32'h0020_81B3, 32'h204, 0, 0);
        checks++;
        if (oINSTR_READY !== 0 || oPC !== 32'h200) begin
            errors++; $display("FAIL b2b_stall: got ready=%b pc=%h, need 0 200", oINSTR_READY, oPC);
        end
        step(1, 32'h0020_81B3, 32'h208, 1, 0);
        checks++;
        if (oPC !== exp_pc[1] || oINSTR_READY !== 1) begin
            errors++; $display("FAIL b2b_second: got pc=%h ready=%b, need %h 1", oPC, oINSTR_READY, exp_pc[1]);
        end
        step(1, 32'h0020_81B3, 32'h208, 1, 0);
        checks++;
        if (oPC !== exp_pc[2] || oFMT !== FMT_R || oRD !== 5'd3 || oRS1 !== 5'd1 || oRS2 !== 5'd2 || oFUNCT7 !== 0) begin
            errors++; $display("FAIL b2b_third: got pc=%h fmt=%0d rd=%0d rs1=%0d rs2=%0d, need %h %0d 3 1 2",
                               oPC, oFMT, oRD, oRS1, oRS2, exp_pc[2], FMT_R);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (oVALID !== 0 || oDEC_CNT !== 32'd6) begin
            errors++; $display("FAIL b2b_count: got valid=%b cnt=%0d, need 0 6", oVALID, oDEC_CNT);
        end
    endtask

    task automatic test_illegal();
        step(1, 32'h0, 32'h300, 1, 0);
        checks++;
        if (oVALID !== 1 || oILLEGAL !== 1 || oFMT !== FMT_NONE || oOPCODE !== 0 || oRD !== 0 || oRS1 !== 0
            || oRS2 !== 0 || oFUNCT3 !== 0 || oFUNCT7 !== 0 || oIMM !== 0 || oDEC_CNT !== m_cnt) begin
            errors++; $display("FAIL illegal: got v=%b ill=%b fmt=%0d imm=%h cnt=%0d, need 1 1 %0d 0 %0d",
                               oVALID, oILLEGAL, oFMT, oIMM, oDEC_CNT, FMT_NONE, m_cnt);
        end
        step(0, 0, 0, 1, 0);
    endtask

    task automatic test_flush();
        logic [31:0] cnt_before;
        step(1, 32'h0020_81B3, 32'h400, 0, 0);
        step(1, 32'h0051_2423, 32'h404, 0, 0);
        cnt_before = m_cnt;
        checks++;
        if (oINSTR_READY !== 0) begin errors++; $display("FAIL flush_full: got ready=%b, need 0", oINSTR_READY); end
        step(1, 32'hFFB1_0093, 32'h408, 1, 1);
        checks++;
        if (oVALID !== 0 || oINSTR_READY !== 1 || oDEC_CNT !== cnt_before) begin
            errors++; $display("FAIL flush_two: got v=%b ready=%b cnt=%0d, need 0 1 %0d",
                               oVALID, oINSTR_READY, oDEC_CNT, cnt_before);
        end
        step(1, 32'h0020_81B3, 32'h40C, 0, 0);
        cnt_before = m_cnt;
        step(1, 32'h0020_81B3, 32'h410, 0, 1);
        checks++;
        if (oVALID !== 0 || oINSTR_READY !== 1 || oDEC_CNT !== cnt_before) begin
            errors++; $display("FAIL flush_one: got v=%b ready=%b cnt=%0d, need 0 1 %0d",
                               oVALID, oINSTR_READY, oDEC_CNT, cnt_before);
        end
    endtask

    task automatic test_async_reset();
        step(1, 32'h0020_81B3, 32'h500, 0, 0);
        step(1, 32'h0010_00EF, 32'h504, 0, 0);
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (oVALID !== 0 || oDEC_CNT !== 0 || oPC !== 0 || oIMM !== 0 || oRD !== 0 || oFMT !== 0) begin
            errors++; $display("FAIL async_reset: got v=%b cnt=%0d pc=%h imm=%h, need all 0",
                               oVALID, oDEC_CNT, oPC, oIMM);
        end
        mq.delete();
        m_cnt = '0;
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (oINSTR_READY !== 1 || oVALID !== 0) begin
            errors++; $display("FAIL async_release: got ready=%b valid=%b, need 1 0", oINSTR_READY, oVALID);
        end
    endtask

    task automatic test_soak();
        logic [6:0]  ops [10];
        logic [31:0] r, w;
        dec_t        e;
        logic        exp_ready, exp_valid;
        ops[0] = OP_R;   ops[1] = OP_IMM;    ops[2] = OP_LOAD;  ops[3] = OP_JALR; ops[4] = OP_STORE;
        ops[5] = OP_BRANCH; ops[6] = OP_LUI; ops[7] = OP_AUIPC; ops[8] = OP_JAL;  ops[9] = 7'h0;
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            ops[9] = 7'($urandom());
            w = {r[31:7], ops[$urandom_range(0, 9)]};
            step(($urandom_range(0, 3) != 0), w, $urandom(), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0));
            exp_ready = (mq.size() < 2);
            exp_valid = (mq.size() > 0);
            checks++;
            if (oINSTR_READY !== exp_ready || oVALID !== exp_valid || oDEC_CNT !== m_cnt) begin
                errors++; $display("FAIL soak_ctrl[%0d]: got ready=%b valid=%b cnt=%0d, need %b %b %0d",
                                   n, oINSTR_READY, oVALID, oDEC_CNT, exp_ready, exp_valid, m_cnt);
            end
            if (mq.size() > 0) begin
                e = ref_decode(mq[0].instr);
                checks++;
                if (oPC !== mq[0].pc || {oOPCODE, oFMT, oRD, oRS1, oRS2, oFUNCT3, oFUNCT7, oIMM, oILLEGAL} !== e) begin
                    errors++; $display("FAIL soak_bundle[%0d]: got pc=%h bundle=%h, need pc=%h bundle=%h",
                                       n, oPC, {oOPCODE, oFMT, oRD, oRS1, oRS2, oFUNCT3, oFUNCT7, oIMM, oILLEGAL},
                                       mq[0].pc, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store_jal();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_async_reset();
        test_soak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
